rtc_bus_sequencer: RTL

//  Transaction scheduler for the multiplexed A/D bus of the RTC chip.
//  - Arbitrates between three requesters: init sequence, register write, register read.
//  - Drives the 4-bit phase number (estado) and the one-hot enables that the bus-timing

---
 rtl/rtc_bus_sequencer_pkg.sv | 30 +++
 rtl/rtc_bus_sequencer_if.sv | 36 +++
 rtl/rtc_bus_sequencer_phase_timer.sv | 48 ++++
 rtl/rtc_bus_sequencer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/rtc_bus_sequencer_pkg.sv
// Shared types and constants for the RTC multiplexed-bus transaction sequencer.
package rtc_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        GAP
    } state_t;

    typedef enum logic [1:0] {
        REQ_INIT,
        REQ_WR,
        REQ_RD
    } req_t;

    // Highest bus phase number; a transaction walks estado 0..PHASE_LAST.
    localparam logic [3:0] PHASE_LAST = 4'd11;

    // Power-up register writes issued in index order; only the first INIT_LEN are used.
    localparam logic [7:0] INIT_ADDR [16] = '{
        8'h02, 8'h10, 8'h02, 8'h00, 8'h01, 8'h03, 8'h04, 8'h05,
        8'h06, 8'h07, 8'h08, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15
    };

    localparam logic [7:0] INIT_DATA [16] = '{
        8'h10, 8'hD2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
        8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

endpackage

// File: rtl/rtc_bus_sequencer_if.sv
// Requester-side handshake and bus-timing control bundle of the RTC sequencer.
interface rtc_bus_if;

    logic       init_req;
    logic       wr_req;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_req;
    logic [7:0] rd_addr;
    logic [2:0] rd_mode;

    logic [3:0] estado;
    logic [2:0] Estado_m;
    logic       enable_inicio;
    logic       enable_escribir;
    logic       enable_leer;
    logic [7:0] addr_out;
    logic [7:0] data_out;
    logic       wr_ack;
    logic       rd_ack;
    logic       init_done;
    logic       busy;

    modport master (
        output init_req, wr_req, wr_addr, wr_data, rd_req, rd_addr, rd_mode,
        input  estado, Estado_m, enable_inicio, enable_escribir, enable_leer,
               addr_out, data_out, wr_ack, rd_ack, init_done, busy
    );

    modport slave (
        input  init_req, wr_req, wr_addr, wr_data, rd_req, rd_addr, rd_mode,
        output estado, Estado_m, enable_inicio, enable_escribir, enable_leer,
               addr_out, data_out, wr_ack, rd_ack, init_done, busy
    );

endinterface

// File: rtl/rtc_bus_sequencer_phase_timer.sv
// Phase timer: holds each bus phase PHASE_CYC clocks and walks estado 0..11 once per start.
module rtc_phase_timer
    import rtc_bus_pkg::*;
#(
    parameter int PHASE_CYC = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    output logic [3:0] estado_o,
    output logic       done_o
);

    logic [7:0] presc_q;
    logic [3:0] phase_q;
    logic       run_q;
    logic       wrap;

    assign wrap     = run_q && (presc_q == 8'(PHASE_CYC - 1));
    assign done_o   = wrap && (phase_q == PHASE_LAST);
    assign estado_o = phase_q;

    // Prescaler and phase counter; a start always restarts from phase 0, the final wrap parks at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            phase_q <= '0;
            run_q   <= 1'b0;
        end else if (start_i) begin
            presc_q <= '0;
            phase_q <= '0;
            run_q   <= 1'b1;
        end else if (run_q) begin
            if (wrap) begin
                presc_q <= '0;
                if (phase_q == PHASE_LAST) begin
                    phase_q <= '0;
                    run_q   <= 1'b0;
                end else begin
                    phase_q <= phase_q + 4'd1;
                end
            end else begin
                presc_q <= presc_q + 8'd1;
            end
        end
    end

endmodule

// File: rtl/rtc_bus_sequencer.sv
// Transaction scheduler for the RTC multiplexed A/D bus: arbitration, latching, acks, init table.
module rtc_bus_sequencer
    import rtc_bus_pkg::*;
#(
    parameter int PHASE_CYC = 4,
    parameter int GAP_CYC   = 2,
    parameter int INIT_LEN  = 4
) (
    input logic    clk,
    input logic    rst_n,
    rtc_bus_if.slave bus
);

    state_t     state_q;
    req_t       req_q;
    logic [3:0] idx_q;
    logic [7:0] gap_q;
    logic       init_pend_q;
    logic       init_done_q;
    logic       last_was_wr_q;
    logic       en_init_q;
    logic       en_wr_q;
    logic       en_rd_q;
    logic [7:0] addr_q;
    logic [7:0] data_q;
    logic [2:0] mode_q;
    logic       wr_ack_q;
    logic       rd_ack_q;
    logic       busy_q;

    logic       grant_d;
    req_t       gsel_d;
    logic [3:0] gidx_d;
    logic       gap_last;
    logic       timer_done;
    logic [3:0] estado;

    assign gap_last = (state_q == GAP) && (gap_q == 8'(GAP_CYC - 1));

    rtc_phase_timer #(
        .PHASE_CYC (PHASE_CYC)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (grant_d),
        .estado_o (estado),
        .done_o   (timer_done)
    );

    // Grant decision: pending init first, then round-robin wr/rd, or chain the next init entry out of GAP.
    always_comb begin
        grant_d = 1'b0;
        gsel_d  = REQ_INIT;
        gidx_d  = '0;
        if (state_q == IDLE) begin
            if (init_pend_q || bus.init_req) begin
                grant_d = 1'b1;
                gsel_d  = REQ_INIT;
            end else if (init_done_q && bus.wr_req && bus.rd_req) begin
                grant_d = 1'b1;
                gsel_d  = last_was_wr_q ? REQ_RD : REQ_WR;
            end else if (init_done_q && bus.wr_req) begin
                grant_d = 1'b1;
                gsel_d  = REQ_WR;
            end else if (init_done_q && bus.rd_req) begin
                grant_d = 1'b1;
                gsel_d  = REQ_RD;
            end
        end else if (gap_last && (req_q == REQ_INIT) && (idx_q != 4'(INIT_LEN - 1))) begin
            grant_d = 1'b1;
            gsel_d  = REQ_INIT;
            gidx_d  = idx_q + 4'd1;
        end
    end

    // Sequencer FSM with registered enables, latched transaction fields and ack pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            req_q         <= REQ_INIT;
            idx_q         <= '0;
            gap_q         <= '0;
            init_pend_q   <= 1'b1;
            init_done_q   <= 1'b0;
            last_was_wr_q <= 1'b0;
            en_init_q     <= 1'b0;
            en_wr_q       <= 1'b0;
            en_rd_q       <= 1'b0;
            addr_q        <= '0;
            data_q        <= '0;
            mode_q        <= '0;
            wr_ack_q      <= 1'b0;
            rd_ack_q      <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            wr_ack_q <= 1'b0;
            rd_ack_q <= 1'b0;
            // A re-init request during an init run is dropped; otherwise it is remembered.
            if (bus.init_req && !((state_q != IDLE) && (req_q == REQ_INIT))) begin
                init_pend_q <= 1'b1;
            end
            if (grant_d) begin
                state_q   <= RUN;
                req_q     <= gsel_d;
                idx_q     <= gidx_d;
                busy_q    <= 1'b1;
                en_init_q <= (gsel_d == REQ_INIT);
                en_wr_q   <= (gsel_d == REQ_WR);
                en_rd_q   <= (gsel_d == REQ_RD);
                case (gsel_d)
                    REQ_WR: begin
                        addr_q        <= bus.wr_addr;
                        data_q        <= bus.wr_data;
                        mode_q        <= '0;
                        last_was_wr_q <= 1'b1;
                    end
                    REQ_RD: begin
                        addr_q        <= bus.rd_addr;
                        data_q        <= '0;
                        mode_q        <= bus.rd_mode;
                        last_was_wr_q <= 1'b0;
                    end
                    default: begin
                        addr_q      <= INIT_ADDR[gidx_d];
                        data_q      <= INIT_DATA[gidx_d];
                        mode_q      <= '0;
                        init_done_q <= 1'b0;
                        init_pend_q <= 1'b1;
                    end
                endcase
            end else begin
                case (state_q)
                    RUN: begin
                        if (timer_done) begin
                            state_q   <= GAP;
                            gap_q     <= '0;
                            en_init_q <= 1'b0;
                            en_wr_q   <= 1'b0;
                            en_rd_q   <= 1'b0;
                            mode_q    <= '0;
                            // Ack is raised on entry to the last GAP clock; with one GAP clock that is now.
                            if (GAP_CYC == 1) begin
                                wr_ack_q <= (req_q == REQ_WR);
                                rd_ack_q <= (req_q == REQ_RD);
                            end
                        end
                    end
                    GAP: begin
                        gap_q <= gap_q + 8'd1;
                        if ((gap_q + 8'd1) == 8'(GAP_CYC - 1)) begin
                            wr_ack_q <= (req_q == REQ_WR);
                            rd_ack_q <= (req_q == REQ_RD);
                        end
                        if (gap_last) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            if (req_q == REQ_INIT) begin
                                init_done_q <= 1'b1;
                                init_pend_q <= 1'b0;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.estado          = estado;
    assign bus.Estado_m        = mode_q;
    assign bus.enable_inicio   = en_init_q;
    assign bus.enable_escribir = en_wr_q;
    assign bus.enable_leer     = en_rd_q;
    assign bus.addr_out        = addr_q;
    assign bus.data_out        = data_q;
    assign bus.wr_ack          = wr_ack_q;
    assign bus.rd_ack          = rd_ack_q;
    assign bus.init_done       = init_done_q;
    assign bus.busy            = busy_q;

endmodule
